// File: rtl/idiv_pkg.sv
// Shared definitions for the multicycle integer divider: op encodings and FSM states.
// Pure declarations; no logic, no latency, no flow control.
package idiv_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/idiv_lzc.sv
// Leading-zero counter; returns WIDTH for an all-zero input.
// Purely combinational, zero latency, no flow control.
module idiv_lzc #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]         a,
    output logic [$clog2(WIDTH+1)-1:0] cnt
);

    localparam int CW = $clog2(WIDTH + 1);

    // Ascending scan so the highest set bit wins.
    always_comb begin
        cnt = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (a[i]) cnt = CW'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/idiv_pipe_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU; IDIV_EARLY_OUT_EN enables leading-zero skip.
// Latency DATA_WIDTH+2 edges (1 for div-by-zero/overflow; DATA_WIDTH-lzc+2 with early-out).
// One op in flight: in_ready only in IDLE; result held in DONE until out_ready.
module idiv_pipe_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_op,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [TAG_WIDTH-1:0]  out_tag
);

    import idiv_pkg::*;

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    state_t               state;
    logic [1:0]           op_r;
    logic [W-1:0]         a_r;
    logic [W-1:0]         b_r;
    logic [TAG_WIDTH-1:0] tag_r;
    logic [W-1:0]         dvd;
    logic [W-1:0]         dsr;
    logic [W:0]           rem;
    logic [CW-1:0]        cnt;
    logic                 qsign;
    logic                 rsign;

    logic         is_signed;
    logic         is_rem;
    logic         sa;
    logic         sb;
    logic [W-1:0] abs_a;
    logic [W-1:0] abs_b;
    logic         div_zero;
    logic         overflow;
    logic [W:0]   rem_shift;
    logic         ge;
    logic [W:0]   rem_next;
    logic [W-1:0] fix_q;
    logic [W-1:0] fix_r;
    logic [W-1:0] pre_dvd;
    logic [CW-1:0] pre_cnt;
    logic         a_zero;

    assign is_signed = (op_r == OP_DIV) || (op_r == OP_REM);
    assign is_rem    = (op_r == OP_REM) || (op_r == OP_REMU);
    assign sa        = is_signed && a_r[W-1];
    assign sb        = is_signed && b_r[W-1];
    // The most-negative value negates to itself, which is its correct unsigned magnitude.
    assign abs_a     = sa ? -a_r : a_r;
    assign abs_b     = sb ? -b_r : b_r;
    assign div_zero  = (b_r == '0);
    assign overflow  = is_signed && (a_r == {1'b1, {(W-1){1'b0}}}) && (b_r == '1);

    assign rem_shift = {rem[W-1:0], dvd[W-1]};
    assign ge        = rem[W] || (rem_shift >= {1'b0, dsr});
    assign rem_next  = ge ? (rem_shift - {1'b0, dsr}) : rem_shift;
    assign fix_q     = qsign ? -dvd : dvd;
    assign fix_r     = rsign ? -rem[W-1:0] : rem[W-1:0];

`ifdef IDIV_EARLY_OUT_EN
    logic [CW-1:0] lzc;

    idiv_lzc #(.WIDTH(W)) u_lzc (
        .a   (abs_a),
        .cnt (lzc)
    );

    // Skipping leading zeros leaves the quotient in the low bits of dvd after fewer steps.
    assign pre_dvd = abs_a << lzc;
    assign pre_cnt = CW'(W) - lzc;
    assign a_zero  = (a_r == '0);
`else
    assign pre_dvd = abs_a;
    assign pre_cnt = CW'(W);
    assign a_zero  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            op_r       <= '0;
            a_r        <= '0;
            b_r        <= '0;
            tag_r      <= '0;
            dvd        <= '0;
            dsr        <= '0;
            rem        <= '0;
            cnt        <= '0;
            qsign      <= 1'b0;
            rsign      <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_r     <= in_op;
                        a_r      <= in_a;
                        b_r      <= in_b;
                        tag_r    <= in_tag;
                        in_ready <= 1'b0;
                        state    <= PREP;
                    end
                end
                PREP: begin
                    qsign <= sa ^ sb;
                    rsign <= sa;
                    dsr   <= abs_b;
                    rem   <= '0;
                    if (div_zero) begin
                        out_result <= is_rem ? a_r : '1;
                        out_tag    <= tag_r;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end else if (overflow) begin
                        out_result <= is_rem ? '0 : a_r;
                        out_tag    <= tag_r;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end else if (a_zero) begin
                        out_result <= '0;
                        out_tag    <= tag_r;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        dvd   <= pre_dvd;
                        cnt   <= pre_cnt;
                        state <= CALC;
                    end
                end
                CALC: begin
                    rem <= rem_next;
                    dvd <= {dvd[W-2:0], ge};
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= FIX;
                end
                FIX: begin
                    out_result <= is_rem ? fix_r : fix_q;
                    out_tag    <= tag_r;
                    out_valid  <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_idiv_pipe_unit.sv
// Directed self-checking bench for idiv_pipe_unit; expected latencies follow IDIV_EARLY_OUT_EN.
module tb_idiv_pipe_unit;

    import idiv_pkg::*;

`ifdef IDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'b00;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [4:0]  out_tag;

    int checks = 0;
    int failures = 0;

    idiv_pipe_unit #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    // Expected accept-to-valid edge count given the hand-computed leading-zero count of |a|.
    function automatic int exp_lat(input int lz);
        if (!EARLY) return 34;
        if (lz == 32) return 1;
        return 34 - lz;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) n = -1;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, output logic [31:0] res,
                          output logic [4:0] otag, output int lat);
        issue(op, a, b, tag);
        wait_valid(lat);
        res  = out_result;
        otag = out_tag;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_result !== 32'h0) begin failures++; $display("FAIL reset_out_result got=%h exp=0", out_result); end
        checks++; if (out_tag !== 5'h0) begin failures++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_signed();
        logic [31:0] res;
        logic [4:0]  tg;
        int          lat;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd3, res, tg, lat);
        checks++; if (res !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_m7_2 got=%h exp=fffffffd", res); end
        checks++; if (tg !== 5'd3) begin failures++; $display("FAIL div_m7_2_tag got=%0d exp=3", tg); end
        checks++; if (lat != exp_lat(29)) begin failures++; $display("FAIL div_m7_2_lat got=%0d exp=%0d", lat, exp_lat(29)); end
        run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd17, res, tg, lat);
        checks++; if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rem_m7_2 got=%h exp=ffffffff", res); end
        checks++; if (tg !== 5'd17) begin failures++; $display("FAIL rem_m7_2_tag got=%0d exp=17", tg); end
        run_op(OP_DIV, 32'd100, 32'hFFFF_FFF9, 5'd1, res, tg, lat);
        checks++; if (res !== 32'hFFFF_FFF2) begin failures++; $display("FAIL div_100_m7 got=%h exp=fffffff2", res); end
        run_op(OP_REM, 32'd100, 32'hFFFF_FFF9, 5'd1, res, tg, lat);
        checks++; if (res !== 32'd2) begin failures++; $display("FAIL rem_100_m7 got=%h exp=2", res); end
        run_op(OP_REM, 32'hFFFF_FF9C, 32'd7, 5'd1, res, tg, lat);
        checks++; if (res !== 32'hFFFF_FFFE) begin failures++; $display("FAIL rem_m100_7 got=%h exp=fffffffe", res); end
    endtask

    task automatic test_div_zero();
        logic [31:0] res;
        logic [4:0]  tg;
        int          lat;
        run_op(OP_DIVU, 32'h1234_5678, 32'd0, 5'd5, res, tg, lat);
        checks++; if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divu_by0 got=%h exp=ffffffff", res); end
        checks++; if (lat != 1) begin failures++; $display("FAIL divu_by0_lat got=%0d exp=1", lat); end
        run_op(OP_REMU, 32'h1234_5678, 32'd0, 5'd6, res, tg, lat);
        checks++; if (res !== 32'h1234_5678) begin failures++; $display("FAIL remu_by0 got=%h exp=12345678", res); end
        checks++; if (tg !== 5'd6) begin failures++; $display("FAIL remu_by0_tag got=%0d exp=6", tg); end
        run_op(OP_REM, 32'hFFFF_FFF9, 32'd0, 5'd7, res, tg, lat);
        checks++; if (res !== 32'hFFFF_FFF9) begin failures++; $display("FAIL rem_by0 got=%h exp=fffffff9", res); end
    endtask

    task automatic test_overflow();
        logic [31:0] res;
        logic [4:0]  tg;
        int          lat;
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, res, tg, lat);
        checks++; if (res !== 32'h8000_0000) begin failures++; $display("FAIL div_ovf got=%h exp=80000000", res); end
        checks++; if (lat != 1) begin failures++; $display("FAIL div_ovf_lat got=%0d exp=1", lat); end
        run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, res, tg, lat);
        checks++; if (res !== 32'h0) begin failures++; $display("FAIL rem_ovf got=%h exp=0", res); end
        run_op(OP_DIV, 32'h8000_0000, 32'd2, 5'd9, res, tg, lat);
        checks++; if (res !== 32'hC000_0000) begin failures++; $display("FAIL div_min_2 got=%h exp=c0000000", res); end
        checks++; if (lat != exp_lat(0)) begin failures++; $display("FAIL div_min_2_lat got=%0d exp=%0d", lat, exp_lat(0)); end
        run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, res, tg, lat);
        checks++; if (res !== 32'h0) begin failures++; $display("FAIL divu_no_ovf got=%h exp=0", res); end
    endtask

    task automatic test_latency();
        logic [31:0] res;
        logic [4:0]  tg;
        int          lat;
        run_op(OP_DIVU, 32'd100, 32'd7, 5'd10, res, tg, lat);
        checks++; if (res !== 32'd14) begin failures++; $display("FAIL divu_100_7 got=%0d exp=14", res); end
        checks++; if (lat != exp_lat(25)) begin failures++; $display("FAIL divu_100_7_lat got=%0d exp=%0d", lat, exp_lat(25)); end
        run_op(OP_REMU, 32'd100, 32'd7, 5'd11, res, tg, lat);
        checks++; if (res !== 32'd2) begin failures++; $display("FAIL remu_100_7 got=%0d exp=2", res); end
        run_op(OP_DIVU, 32'd0, 32'd5, 5'd12, res, tg, lat);
        checks++; if (res !== 32'd0) begin failures++; $display("FAIL divu_0_5 got=%0d exp=0", res); end
        checks++; if (lat != exp_lat(32)) begin failures++; $display("FAIL divu_0_5_lat got=%0d exp=%0d", lat, exp_lat(32)); end
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd13, res, tg, lat);
        checks++; if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divu_max_1 got=%h exp=ffffffff", res); end
    endtask

    task automatic test_backpressure();
        int lat;
        issue(OP_DIVU, 32'd100, 32'd7, 5'd9);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, out_valid); end
            checks++; if (out_result !== 32'd14) begin failures++; $display("FAIL bp_result cyc=%0d got=%0d exp=14", i, out_result); end
            checks++; if (out_tag !== 5'd9) begin failures++; $display("FAIL bp_tag cyc=%0d got=%0d exp=9", i, out_tag); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        logic [4:0]  tg;
        int          lat;
        issue(OP_DIV, 32'h7FFF_FFFF, 32'd3, 5'd4);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
        run_op(OP_DIVU, 32'd100, 32'd7, 5'd6, res, tg, lat);
        checks++; if (res !== 32'd14) begin failures++; $display("FAIL post_flush_result got=%0d exp=14", res); end
        checks++; if (tg !== 5'd6) begin failures++; $display("FAIL post_flush_tag got=%0d exp=6", tg); end
        checks++; if (lat != exp_lat(25)) begin failures++; $display("FAIL post_flush_lat got=%0d exp=%0d", lat, exp_lat(25)); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        logic [4:0]  tg;
        int          lat;
        bit          seen = 1'b0;
        issue(OP_DIVU, 32'd1000, 32'd3, 5'd2);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid); end
        #2 rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_mid_no_output got=%b exp=0", seen); end
        run_op(OP_DIVU, 32'd1000, 32'd3, 5'd2, res, tg, lat);
        checks++; if (res !== 32'd333) begin failures++; $display("FAIL post_rst_result got=%0d exp=333", res); end
    endtask

    initial begin
        test_reset();
        test_signed();
        test_div_zero();
        test_overflow();
        test_latency();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
